fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the opcode decoder/controller.
//  Holds the PC and issues word reads to the synchronous instruction ROM (1-cycle read latency).
//  Presents one instruction per cycle to decode with a valid/stall handshake.
//  A one-entry skid buffer guarantees no fetched word is lost or duplicated under stall or redirect.
// PARAMETERS
//  ADDR_W    12  instruction-memory word-address width; PC width
//  DATA_W    32  instruction width
//  RESET_PC  0   first PC fetched after reset
// PORTS
//  clock           in   1       single clock; all state updates on rising edge
//  reset           in   1       asynchronous, active-high
//  imem_addr       out  ADDR_W  ROM word address (= pc register)
//  imem_rd_en      out  1       request issued this cycle; ROM samples addr at next edge
//  imem_q          in   DATA_W  ROM data; valid the cycle after an issuing edge
//  stall           in   1       decode cannot accept; consumer ready = ~stall
//  redirect_valid  in   1       flush and restart fetch at redirect_pc
//  redirect_pc     in   ADDR_W  new fetch address
//  instr_valid     out  1       instr/instr_pc hold a live instruction
//  instr           out  DATA_W  instruction word (registered)
//  instr_pc        out  ADDR_W  address the instruction came from
//  opcode          out  5       instr[31:27]; feeds controller opCode; 0 when ~instr_valid
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC; instr_valid, skid_valid, req_valid=0; instr, instr_pc=0; imem_rd_en=0.
//  Internal regs: pc; req_valid/req_pc (word for req_pc arrives on imem_q this cycle);
//   out regs (instr_valid/instr/instr_pc); skid (skid_valid/skid_instr/skid_pc).
//  Transfer: a word is consumed at an edge where instr_valid=1 and stall=0.
//  Issue rule: imem_rd_en = ~reset & ~skid_valid & ~(stall & instr_valid & req_valid).
//   On an issuing edge: req_pc<=pc, req_valid<=1, pc<=pc+1 (mod 2^ADDR_W, wraps to 0).
//   On a non-issuing edge: req_valid<=0, pc unchanged.
//  Returning word (req_valid=1), same edge:
//   - out empty, or out consumed with skid empty -> word goes to out regs.
//   - out held (instr_valid & stall) -> word goes to skid.
//  Out refill when out consumed and skid_valid: skid moves to out (order preserved);
//   skid is then refilled by any returning word, else skid_valid<=0.
//  Invariant: in-flight + out + skid <= 2 entries beyond out; skid never overwritten while valid.
//  Latency: an instruction issued at edge k is instr_valid after edge k+1 (no stall).
//   First instruction after reset release: instr_valid in cycle 2 (RESET_PC).
//  Steady state, no stall: one instruction per cycle, instr_pc increments by 1.
//  Redirect (priority over stall and all other updates): at the edge with redirect_valid=1:
//   instr_valid, skid_valid, req_valid <= 0; pc <= redirect_pc; any imem_q word that cycle is dropped.
//   imem_rd_en is forced 0 in the redirect cycle.
//   First redirected instruction is valid 2 edges after the redirect edge.
//  Stall with instr_valid=0: no effect on acceptance (nothing to hold); fetch continues.
//  Reset mid-operation: all state returns to reset values immediately; in-flight ROM data is ignored.
//  opcode is combinational from out regs; never X after reset.
// TESTING
//  1 Reset release, ROM[i]=i*0x0800_0001, no stall -> instr_valid from cycle 2; instr_pc 0,1,2..., instr=ROM[pc].
//  2 Stall held 3 cycles while instr_pc=4 valid -> instr_pc stays 4; skid captures 5; imem_rd_en=0 during stall.
//    Release -> instr_pc 5,6,... with no gap, loss or duplicate.
//  3 redirect_valid with redirect_pc=0x100 while stall=1 and skid full -> next edge instr_valid=0.
//    2 edges later instr_pc=0x100; old PCs never reappear.
//  4 Redirect to 0xFFE -> instr_pc 0xFFE, 0xFFF, 0x000 (wrap), continuous.
//  5 Assert reset asynchronously mid-stream (between edges) -> outputs 0 immediately.
//    After release, refetch from RESET_PC.
//  6 Random stall/redirect, checked against a reference PC-sequence model:
//    consumed stream matches program order between redirects.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous ROM requests and a one-entry skid buffer
// presenting one instruction per cycle to decode over a valid/stall handshake.
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_rd_en_o,
  input  logic [DATA_W-1:0] imem_q_i,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [4:0]        opcode_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic consume;
  logic hold;
  logic issue;

  assign consume = instr_valid_q & ~stall_i;
  assign hold    = instr_valid_q & stall_i;
  // Never issue more than the out register and skid can absorb.
  assign issue   = ~reset_i & ~redirect_valid_i & ~skid_valid_q & ~(hold & req_valid_q);

  always_comb begin
    pc_d          = pc_q;
    req_valid_d   = 1'b0;
    req_pc_d      = req_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;

    if (redirect_valid_i) begin
      pc_d          = redirect_pc_i;
      instr_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
    end else begin
      if (issue) begin
        req_pc_d    = pc_q;
        req_valid_d = 1'b1;
        pc_d        = pc_q + ADDR_W'(1);
      end

      if (!instr_valid_q) begin
        if (req_valid_q) begin
          instr_valid_d = 1'b1;
          instr_d       = imem_q_i;
          instr_pc_d    = req_pc_q;
        end
      end else if (consume) begin
        if (skid_valid_q) begin
          instr_d    = skid_instr_q;
          instr_pc_d = skid_pc_q;
          if (req_valid_q) begin
            skid_instr_d = imem_q_i;
            skid_pc_d    = req_pc_q;
          end else begin
            skid_valid_d = 1'b0;
          end
        end else if (req_valid_q) begin
          instr_d    = imem_q_i;
          instr_pc_d = req_pc_q;
        end else begin
          instr_valid_d = 1'b0;
        end
      end else if (hold && req_valid_q && !skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_q_i;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign imem_rd_en_o  = issue;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign opcode_o      = instr_valid_q ? instr_q[DATA_W-1 -: 5] : 5'd0;

endmodule
